// File: rtl/sram_controller_if.sv
// MEM-stage request/response and SRAM pin bundle for sram_controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage accesses into two 16-bit async SRAM cycles plus
// programmable wait cycles, holding ready low until the access completes.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst,
  sram_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_wr;
  logic [31:0] hold;
  logic [31:0] rd_q;
  logic [3:0]  cnt;
  logic        req;
  logic [16:0] word;

  assign req  = bus.wr_en | bus.rd_en;
  // Offset wraps modulo 2^32; only bits [18:2] select the SRAM word.
  assign word = 17'((lat_addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      hold     <= '0;
      rd_q     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_addr <= bus.address;
            lat_data <= bus.write_data;
            lat_wr   <= bus.wr_en;
          end
        end
        S_LO: begin
          if (!lat_wr) hold[15:0] <= bus.sram_dq_in;
        end
        S_HI: begin
          if (!lat_wr) hold[31:16] <= bus.sram_dq_in;
          cnt <= 4'(WAIT_CYCLES - 1);
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          else if (!lat_wr) rd_q <= hold;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_LO;
      S_LO:    state_nxt = S_HI;
      S_HI:    state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // SRAM pins depend only on state and latched registers, never on live requests.
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    bus.ready       = 1'b0;
    case (state)
      S_IDLE: bus.ready = !req;
      S_LO: begin
        bus.sram_addr = {word, 1'b0};
        if (lat_wr) begin
          bus.sram_we_n   = 1'b0;
          bus.sram_dq_oe  = 1'b1;
          bus.sram_dq_out = lat_data[15:0];
        end
      end
      S_HI: begin
        bus.sram_addr = {word, 1'b1};
        if (lat_wr) begin
          bus.sram_we_n   = 1'b0;
          bus.sram_dq_oe  = 1'b1;
          bus.sram_dq_out = lat_data[31:16];
        end
      end
      S_WAIT: bus.sram_addr = {word, 1'b1};
      S_DONE: begin
        bus.sram_addr = {word, 1'b1};
        bus.ready     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.read_data = rd_q;
  assign bus.sram_ce_n = 1'b0;
  assign bus.sram_oe_n = 1'b0;
  assign bus.sram_ub_n = 1'b0;
  assign bus.sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized and directed bench for sram_controller against a word-level memory model.
module tb_sram_controller;
  localparam int unsigned BASE   = 1024;
  localparam int unsigned WAIT   = 3;
  localparam int          DONE_K = WAIT + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus ();

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Pin-level SRAM: unwritten locations return a fixed address-derived pattern.
  logic [15:0] sram_mem [0:262143];
  bit          written  [0:262143];

  function automatic logic [15:0] pat(input logic [17:0] h);
    return h[15:0] ^ 16'h5A3C;
  endfunction

  assign bus.sram_dq_in = written[bus.sram_addr] ? sram_mem[bus.sram_addr] : pat(bus.sram_addr);

  always @(posedge clk) begin
    if (!bus.sram_we_n && bus.sram_dq_oe) begin
      sram_mem[bus.sram_addr] <= bus.sram_dq_out;
      written[bus.sram_addr]  <= 1'b1;
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [int unsigned];
  logic [31:0] last_rd;

  logic [17:0] tr_addr [0:63];
  logic [15:0] tr_dq   [0:63];
  logic        tr_we   [0:63];
  logic        tr_oe   [0:63];
  logic        tr_rdy  [0:63];

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % 131072;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned w);
    logic [17:0] h;
    if (model_mem.exists(w)) return model_mem[w];
    h = 18'(w * 2);
    return {pat(h + 18'd1), pat(h)};
  endfunction

  task automatic capture(input int k);
    tr_addr[k] = bus.sram_addr;
    tr_dq[k]   = bus.sram_dq_out;
    tr_we[k]   = bus.sram_we_n;
    tr_oe[k]   = bus.sram_dq_oe;
    tr_rdy[k]  = bus.ready;
  endtask

  // Caller is at posedge+#1; request is held until cycle index `hold`.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input int hold,
                            output int rdy_k, output logic [31:0] rdata);
    int k;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
    rdy_k = -1; rdata = '0; k = 0;
    @(negedge clk); capture(0);
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k >= hold) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; end
      @(negedge clk); capture(k);
      if (bus.ready) begin rdy_k = k; rdata = bus.read_data; break; end
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.address = '0; bus.write_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_rd = '0;
    @(negedge clk);
    tests_run++;
    if (bus.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    tests_run++;
    if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      tests_failed++; $display("FAIL reset_we_oe got we_n=%b oe=%b exp we_n=1 oe=0", bus.sram_we_n, bus.sram_dq_oe);
    end
    tests_run++;
    if (bus.read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_read_data got=%h exp=0", bus.read_data); end
    tests_run++;
    if (bus.sram_addr !== 18'h0 || bus.sram_dq_out !== 16'h0) begin
      tests_failed++; $display("FAIL reset_addr_dq got addr=%h dq=%h exp 0/0", bus.sram_addr, bus.sram_dq_out);
    end
    tests_run++;
    if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_ub_n, bus.sram_lb_n} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_tied_pins got=%b exp=0000",
        {bus.sram_ce_n, bus.sram_oe_n, bus.sram_ub_n, bus.sram_lb_n});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int rk; logic [31:0] rd; bit low;
    run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 99, rk, rd);
    model_mem[word_of(32'd1028)] = 32'hDEADBEEF;
    tests_run++;
    if (rk !== DONE_K) begin tests_failed++; $display("FAIL write_latency got=%0d exp=%0d", rk, DONE_K); end
    tests_run++;
    if (tr_addr[1] !== 18'd2 || tr_dq[1] !== 16'hBEEF || tr_we[1] !== 1'b0) begin
      tests_failed++; $display("FAIL write_lo got addr=%0d dq=%h we_n=%b exp 2/beef/0", tr_addr[1], tr_dq[1], tr_we[1]);
    end
    tests_run++;
    if (tr_addr[2] !== 18'd3 || tr_dq[2] !== 16'hDEAD || tr_we[2] !== 1'b0) begin
      tests_failed++; $display("FAIL write_hi got addr=%0d dq=%h we_n=%b exp 3/dead/0", tr_addr[2], tr_dq[2], tr_we[2]);
    end
    low = 1'b1;
    for (int k = 0; k < DONE_K; k++) if (tr_rdy[k] !== 1'b0) low = 1'b0;
    tests_run++;
    if (!low) begin tests_failed++; $display("FAIL write_ready_low got early ready exp low until k=%0d", DONE_K); end
    tests_run++;
    if (rd !== last_rd) begin tests_failed++; $display("FAIL write_read_data got=%h exp=%h", rd, last_rd); end
  endtask

  task automatic test_read();
    int rk; logic [31:0] rd; bit we_hi;
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 99, rk, rd);
    tests_run++;
    if (rk !== DONE_K) begin tests_failed++; $display("FAIL read_latency got=%0d exp=%0d", rk, DONE_K); end
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read_data got=%h exp=deadbeef", rd); end
    last_rd = model_read(word_of(32'd1028));
    we_hi = 1'b1;
    for (int k = 0; k <= DONE_K; k++) if (tr_we[k] !== 1'b1 || tr_oe[k] !== 1'b0) we_hi = 1'b0;
    tests_run++;
    if (!we_hi) begin tests_failed++; $display("FAIL read_no_strobe got we_n low or oe high exp we_n=1 oe=0"); end
  endtask

  task automatic test_back_to_back();
    int rk1, rk2; logic [31:0] rd1, rd2;
    run_access(1'b1, 1'b0, 32'd1024, 32'h11112222, 99, rk1, rd1);
    model_mem[word_of(32'd1024)] = 32'h11112222;
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 99, rk2, rd2);
    tests_run++;
    if (rk1 !== DONE_K || rk2 !== DONE_K || tr_rdy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_ready got k1=%0d k2=%0d rdy0=%b exp %0d/%0d/0", rk1, rk2, tr_rdy[0], DONE_K, DONE_K);
    end
    tests_run++;
    if (rd2 !== model_read(word_of(32'd1024))) begin
      tests_failed++; $display("FAIL b2b_read_data got=%h exp=%h", rd2, model_read(word_of(32'd1024)));
    end
    last_rd = model_read(word_of(32'd1024));
  endtask

  task automatic test_simultaneous_dropped();
    int rk; logic [31:0] rd; logic [31:0] a;
    a = BASE + 32'd400;
    run_access(1'b1, 1'b1, a, 32'hCAFE0123, 99, rk, rd);
    model_mem[word_of(a)] = 32'hCAFE0123;
    tests_run++;
    if (tr_we[1] !== 1'b0 || tr_we[2] !== 1'b0 || tr_dq[1] !== 16'h0123) begin
      tests_failed++; $display("FAIL both_is_write got we1=%b we2=%b dq1=%h exp 0/0/0123", tr_we[1], tr_we[2], tr_dq[1]);
    end
    tests_run++;
    if (rd !== last_rd) begin tests_failed++; $display("FAIL both_read_data got=%h exp=%h", rd, last_rd); end
    run_access(1'b0, 1'b1, a, 32'h0, 2, rk, rd);
    tests_run++;
    if (rk !== DONE_K) begin tests_failed++; $display("FAIL dropped_latency got=%0d exp=%0d", rk, DONE_K); end
    tests_run++;
    if (rd !== model_read(word_of(a))) begin tests_failed++; $display("FAIL dropped_read_data got=%h exp=%h", rd, model_read(word_of(a))); end
    last_rd = model_read(word_of(a));
  endtask

  task automatic test_reset_mid_access();
    int rk; logic [31:0] rd; logic [31:0] a; logic [31:0] old; bit quiet;
    a = BASE + 32'd2000;
    old = model_read(word_of(a));
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = a; bus.write_data = 32'h89ABCDEF;
    @(negedge clk);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.sram_we_n !== 1'b0) begin tests_failed++; $display("FAIL rstmid_lo_strobe got we_n=%b exp=0", bus.sram_we_n); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_mem[word_of(a)] = {old[31:16], 16'hCDEF};
    last_rd = '0;
    @(negedge clk);
    tests_run++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'h0 || bus.sram_addr !== 18'h0) begin
      tests_failed++; $display("FAIL rstmid_idle got ready=%b rd=%h addr=%h exp 1/0/0", bus.ready, bus.read_data, bus.sram_addr);
    end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!quiet) begin tests_failed++; $display("FAIL rstmid_no_hi_strobe got a strobe after reset exp none"); end
    @(posedge clk); #1;
    run_access(1'b0, 1'b1, a, 32'h0, 1, rk, rd);
    tests_run++;
    if (rk !== DONE_K || rd !== model_read(word_of(a))) begin
      tests_failed++; $display("FAIL rstmid_recover got k=%0d rd=%h exp k=%0d rd=%h", rk, rd, DONE_K, model_read(word_of(a)));
    end
    last_rd = model_read(word_of(a));
  endtask

  task automatic test_random();
    int rk; logic [31:0] rd; logic [31:0] a; logic [31:0] d; logic [31:0] exp;
    int unsigned sel, w; logic wr, rdq; logic [16:0] w17; logic [17:0] ea; bit ok, low;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 2);
      wr  = (sel != 1);
      rdq = (sel != 0);
      case ($urandom_range(0, 5))
        0:       a = BASE - 32'd4;
        1:       a = BASE + 32'h0008_0000 + 32'd12;
        2:       a = $urandom;
        default: a = BASE + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
      endcase
      d = $urandom;
      run_access(wr, rdq, a, d, $urandom_range(1, DONE_K + 1), rk, rd);
      w = word_of(a);
      w17 = 17'(w);
      if (wr) begin
        model_mem[w] = d;
        exp = last_rd;
      end else begin
        exp = model_read(w);
        last_rd = exp;
      end
      tests_run++;
      if (rd !== exp) begin tests_failed++; $display("FAIL rand_read_data n=%0d got=%h exp=%h", n, rd, exp); end
      low = 1'b1;
      for (int k = 0; k < DONE_K; k++) if (tr_rdy[k] !== 1'b0) low = 1'b0;
      tests_run++;
      if (rk !== DONE_K || !low) begin tests_failed++; $display("FAIL rand_ready n=%0d got k=%0d early=%b exp k=%0d", n, rk, !low, DONE_K); end
      ok = 1'b1;
      for (int k = 1; k <= DONE_K; k++) begin
        ea = (k == 1) ? {w17, 1'b0} : {w17, 1'b1};
        if (tr_addr[k] !== ea) ok = 1'b0;
        if (tr_we[k] !== !(wr && k <= 2) || tr_oe[k] !== (wr && k <= 2)) ok = 1'b0;
        if (wr && k == 1 && tr_dq[k] !== d[15:0]) ok = 1'b0;
        if (wr && k == 2 && tr_dq[k] !== d[31:16]) ok = 1'b0;
      end
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rand_pins n=%0d got addr1=%h addr2=%h we1=%b dq1=%h exp addr1=%h wr=%b dq=%h",
                 n, tr_addr[1], tr_addr[2], tr_we[1], tr_dq[1], {w17, 1'b0}, wr, d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_simultaneous_dropped();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences the pipeline's 32-bit data-memory accesses onto an external 16-bit asynchronous SRAM. It sits between the MEM stage and the SRAM pins. It splits each word access into a low-half and a high-half SRAM cycle, then inserts programmable wait cycles. Its `ready` output freezes the pipeline until the access completes.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 3: idle cycles after the high-half access, before completion. Legal range is 1..15.
- `clk`, input, 1: system clock, single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: word write request from the MEM stage.
- `rd_en`, input, 1: word read request from the MEM stage.
- `address`, input, 32: byte address; bits [1:0] are ignored.
- `write_data`, input, 32: store data.
- `read_data`, output, 32: load result, registered.
- `ready`, output, 1: high when no access is pending, or on the completion cycle. Low means freeze the pipeline.
- `sram_addr`, output, 18: SRAM halfword address.
- `sram_dq_out`, output, 16: data driven toward the SRAM.
- `sram_dq_oe`, output, 1: data-bus output enable (drives the top-level tristate).
- `sram_dq_in`, input, 16: data read back from the SRAM.
- `sram_we_n`, output, 1: write strobe, active low.
- `sram_ce_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n`, output, 1 each: tied to 0 (always enabled, both byte lanes).

## Operation
- States: IDLE, LO, HI, WAIT, DONE. State and latched request registers are updated on `clk` edges only.
- **IDLE**
  - If `wr_en` or `rd_en` is high: latch `address`, `write_data` and the operation, then go to LO.
  - If both are high, the access is a write.
  - Otherwise stay in IDLE.
- **Address mapping**
  - offset = latched address − `BASE_ADDR`, modulo 2^32.
  - word = offset[18:2].
  - `sram_addr` = {word, 0} in LO and {word, 1} in HI.
  - Addresses outside the SRAM range wrap silently; no error is flagged.
- **LO state**
  - Write: `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out`=latched data[15:0].
  - Read: `sram_we_n`=1, `sram_dq_oe`=0; `sram_dq_in` is captured into a holding register [15:0] at the end of the cycle.
- **HI state**
  - Same as LO, using data[31:16] and capturing into holding register bits [31:16].
  - On exit, load the counter with `WAIT_CYCLES`−1 and go to WAIT.
- **WAIT**
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr` holds the HI value.
  - Decrement the counter; go to DONE when the counter is 0 at the clock edge.
- **DONE**
  - `ready`=1.
  - On a read, `read_data` takes the holding register at the edge entering DONE, so it is valid throughout DONE.
  - Go to IDLE unconditionally.
- **`ready`** is combinational: (state==IDLE and not (`wr_en` or `rd_en`)) or state==DONE.
- **Request handling**
  - Once latched, an access always completes. Dropping `rd_en`/`wr_en` mid-access does not abort it.
  - Input changes after latching are ignored.
- **Write cycles:** `read_data` is unchanged.
- **Glitch-free SRAM pins:** SRAM pins are decoded only from state and latched registers. There is no combinational path from `wr_en`, `rd_en`, `address` or `write_data` to any `sram_*` output.

## Timing
- **Reset values:** state=IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, counter=0; `ready`=1 when no request is present.
- **Latency:** a request first seen in IDLE at cycle T produces:
  - LO at T+1 and HI at T+2;
  - WAIT over T+3 .. T+2+`WAIT_CYCLES`;
  - DONE (`ready`=1) at T+3+`WAIT_CYCLES`. With the default this is T+6.
- **Ready:** `ready` is low from T through T+2+`WAIT_CYCLES`, exactly one DONE cycle per access.
- **Back-to-back requests:**
  - The pipeline advances on the DONE edge. The next request is seen in IDLE at T+4+`WAIT_CYCLES`, with `ready` low that cycle.
  - The minimum spacing between accesses is `WAIT_CYCLES`+4 cycles.
- **SRAM interface timing:**
  - The write strobe is low for exactly one cycle per half, with address and data stable for the whole cycle.
  - The SRAM read is asynchronous and must be valid within the LO/HI cycle.
- **Reset mid-access:** at the next edge, return to IDLE with all reset values. No further write strobe is issued, and `read_data` is cleared.

## Test plan
- **Reset:** hold `rst` 2 cycles, no requests -> `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0.
- **Write:** write 0xDEADBEEF to address 1028 at T.
  - `sram_addr`=2 with dq 0xBEEF and `we_n`=0 at T+1.
  - `sram_addr`=3 with dq 0xDEAD and `we_n`=0 at T+2.
  - `ready`=1 only at T+6.
- **Read-back:** read address 1028 with the SRAM model preloaded with the above -> `read_data`=0xDEADBEEF and `ready`=1 at T+6; `sram_we_n` stays 1 throughout.
- **Back-to-back:** write 1024←0x11112222, then immediately read 1024 -> `ready` pulses at T+6 and T+13; `read_data`=0x11112222 at T+13.
- **Simultaneous and dropped requests:**
  - `rd_en`=`wr_en`=1 -> performs a write and `read_data` is unchanged.
  - Deassert `rd_en` at T+2 -> the access still completes, with `ready` at T+6.
- **Reset mid-access:** assert `rst` at T+1 of a write -> IDLE at T+2, HI strobe never issued, `sram_we_n`=1; a new request completes normally afterward.
